// File: rtl/ser_link_pkg.sv
// Shared definitions for the serial link: receiver state encoding, shift-direction codes, default word width.
package ser_link_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        PAR   = 2'b10
    } rx_state_t;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

    localparam int SER_WIDTH_DEF = 8;

endpackage

// File: rtl/rx_hold_reg.sv
// One-entry holding register for received words; commit to D_vld takes 1 cycle.
// A commit while full is accepted only if the held word drains in the same cycle; otherwise ovr_evt pulses.
import ser_link_pkg::*;

module rx_hold_reg #(
    parameter int WIDTH = SER_WIDTH_DEF
) (
    input  logic             CLK,
    input  logic             Clr_b,
    input  logic             commit_vld,
    input  logic [WIDTH-1:0] commit_dat,
    input  logic             D_rdy,
    output logic [WIDTH-1:0] D_par,
    output logic             D_vld,
    output logic             ovr_evt
);

    logic take;
    logic load;

    assign take    = D_vld & D_rdy;
    assign load    = commit_vld & (~D_vld | D_rdy);
    assign ovr_evt = commit_vld & D_vld & ~D_rdy;

    // D_par is left alone on consume so the consumer can still look at the last word
    always_ff @(posedge CLK or negedge Clr_b) begin
        if (!Clr_b) begin
            D_par <= '0;
            D_vld <= 1'b0;
        end else if (load) begin
            D_par <= commit_dat;
            D_vld <= 1'b1;
        end else if (take) begin
            D_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/ser2par_rx.sv
// Serial-to-parallel receiver (MSB/LSB-first) with valid/ready holding register; D_vld 1 cycle after last bit, overrun drops new word.
// Optional even-parity bit after the data field when SER2PAR_PARITY_EN is defined.
import ser_link_pkg::*;

module ser2par_rx #(
    parameter int WIDTH = SER_WIDTH_DEF
) (
    input  logic             CLK,
    input  logic             Clr_b,
    input  logic             ser_in,
    input  logic             ser_vld,
    input  logic             ser_sof,
    input  logic             dir,
    output logic [WIDTH-1:0] D_par,
    output logic             D_vld,
    input  logic             D_rdy,
    output logic             busy,
    output logic             ovr,
    output logic             perr,
    input  logic             flag_clr
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    rx_state_t        state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n, shifted, first_word, commit_dat;
    logic [CW-1:0]    cnt, cnt_n;
    logic             dir_q, dir_n;
    logic             commit, ovr_evt;
`ifdef SER2PAR_PARITY_EN
    logic             perr_evt;
`endif

    always_comb begin
        shifted    = (dir_q == DIR_MSB_FIRST) ? {shreg[WIDTH-2:0], ser_in}
                                              : {ser_in, shreg[WIDTH-1:1]};
        first_word = (dir == DIR_MSB_FIRST) ? {{(WIDTH-1){1'b0}}, ser_in}
                                            : {ser_in, {(WIDTH-1){1'b0}}};
    end

    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        cnt_n      = cnt;
        dir_n      = dir_q;
        commit     = 1'b0;
        commit_dat = shifted;
`ifdef SER2PAR_PARITY_EN
        perr_evt   = 1'b0;
`endif
        // SOF wins in every state: a partial frame is abandoned without any flag
        if (ser_vld && ser_sof) begin
            dir_n   = dir;
            shreg_n = first_word;
            cnt_n   = CW'(1);
            state_n = SHIFT;
        end else if (ser_vld) begin
            case (state)
                IDLE: ;
                SHIFT: begin
                    shreg_n = shifted;
                    if (cnt == LAST_CNT) begin
`ifdef SER2PAR_PARITY_EN
                        cnt_n   = cnt + CW'(1);
                        state_n = PAR;
`else
                        commit  = 1'b1;
                        cnt_n   = '0;
                        state_n = IDLE;
`endif
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
`ifdef SER2PAR_PARITY_EN
                PAR: begin
                    commit_dat = shreg;
                    commit     = ~(^shreg ^ ser_in);
                    perr_evt   = ^shreg ^ ser_in;
                    cnt_n      = '0;
                    state_n    = IDLE;
                end
`endif
                default: begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge Clr_b) begin
        if (!Clr_b) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
            dir_q <= DIR_MSB_FIRST;
            busy  <= 1'b0;
            ovr   <= 1'b0;
        end else begin
            state <= state_n;
            shreg <= shreg_n;
            cnt   <= cnt_n;
            dir_q <= dir_n;
            busy  <= (state_n != IDLE);
            ovr   <= ovr_evt | (ovr & ~flag_clr);
        end
    end

`ifdef SER2PAR_PARITY_EN
    always_ff @(posedge CLK or negedge Clr_b) begin
        if (!Clr_b) perr <= 1'b0;
        else        perr <= perr_evt | (perr & ~flag_clr);
    end
`else
    assign perr = 1'b0;
`endif

    rx_hold_reg #(.WIDTH(WIDTH)) u_hold (
        .CLK        (CLK),
        .Clr_b      (Clr_b),
        .commit_vld (commit),
        .commit_dat (commit_dat),
        .D_rdy      (D_rdy),
        .D_par      (D_par),
        .D_vld      (D_vld),
        .ovr_evt    (ovr_evt)
    );

endmodule

// File: tb/tb_ser2par_rx.sv
// Bench for ser2par_rx: directed cases plus random frames against a queue-based word model.
module tb_ser2par_rx;
    import ser_link_pkg::*;

    localparam int W = 8;
`ifdef SER2PAR_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic         CLK = 1'b0;
    logic         Clr_b = 1'b0;
    logic         ser_in = 1'b0, ser_vld = 1'b0, ser_sof = 1'b0, dir = 1'b0;
    logic         D_rdy = 1'b1, flag_clr = 1'b0;
    logic [W-1:0] D_par;
    logic         D_vld, busy, ovr, perr;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_w;
    int           bad_cnt = 0;
    logic [0:W-1] seq;

    ser2par_rx #(.WIDTH(W)) dut (
        .CLK(CLK), .Clr_b(Clr_b), .ser_in(ser_in), .ser_vld(ser_vld),
        .ser_sof(ser_sof), .dir(dir), .D_par(D_par), .D_vld(D_vld),
        .D_rdy(D_rdy), .busy(busy), .ovr(ovr), .perr(perr), .flag_clr(flag_clr)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    // Monitor: every accepted word must be the oldest expected one
    always @(negedge CLK) begin
        if (Clr_b && D_vld && D_rdy) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got %0h required none", D_par);
            end else begin
                exp_w = exp_q.pop_front();
                if (D_par !== exp_w) begin
                    errors++;
                    $display("FAIL word: got %0h required %0h", D_par, exp_w);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Non-SOF bits carry a random dir: the receiver must hold the dir latched at SOF
    task automatic send_bit(input logic b, input logic sof, input logic d);
        ser_in  = b;
        ser_sof = sof;
        dir     = sof ? d : 1'($urandom_range(0, 1));
        ser_vld = 1'b1;
        @(posedge CLK);
        #1;
        ser_vld = 1'b0;
        ser_sof = 1'b0;
    endtask

    task automatic send_seq(input logic [0:W-1] s, input logic d, input int gap);
        for (int i = 0; i < W; i++) begin
            send_bit(s[i], i == 0, d);
            if (gap > 0 && (i < W - 1 || PAR_EN)) idle(gap);
        end
        if (PAR_EN) send_bit(^s, 1'b0, d);
    endtask

    task automatic send_frame(input logic [W-1:0] w, input logic d, input int gap,
                              input bit bad_par, input bit push, input bit rdy_last);
        bit good;
        good = 1'b1;
`ifdef SER2PAR_PARITY_EN
        good = !bad_par;
`endif
        if (push && good) exp_q.push_back(w);
        for (int i = 0; i < W; i++) begin
            if (rdy_last && i == W - 1 && !PAR_EN) D_rdy = 1'b1;
            send_bit((d == DIR_MSB_FIRST) ? w[W-1-i] : w[i], i == 0, d);
            if (gap > 0 && (i < W - 1 || PAR_EN)) idle(gap);
        end
        if (PAR_EN) begin
            if (rdy_last) D_rdy = 1'b1;
            send_bit((^w) ^ bad_par, 1'b0, d);
        end
    endtask

    initial begin
        logic [W-1:0] w;
        logic         d;
        int           k;
        bit           bad;

        idle(2);
        chk("reset_D_par", D_par, 0);
        chk("reset_D_vld", D_vld, 0);
        chk("reset_busy", busy, 0);
        chk("reset_ovr", ovr, 0);
        chk("reset_perr", perr, 0);
        Clr_b = 1'b1;
        idle(1);

        // MSB-first 1,0,1,1,0,0,1,0 -> B2, with busy and latency checks
        seq = 8'b10110010;
        exp_q.push_back(8'hB2);
        send_bit(seq[0], 1'b1, DIR_MSB_FIRST);
        chk("busy_after_sof", busy, 1);
        for (int i = 1; i < W; i++) begin
            if (i == W - 1 && !PAR_EN) chk("vld_before_last", D_vld, 0);
            send_bit(seq[i], 1'b0, DIR_MSB_FIRST);
        end
        if (PAR_EN) begin
            chk("vld_before_parity", D_vld, 0);
            send_bit(^seq, 1'b0, DIR_MSB_FIRST);
        end
        chk("vld_latency", D_vld, 1);
        chk("busy_after_done", busy, 0);
        idle(2);

        // LSB-first same bits -> 4D, continuous and with 3-cycle gaps
        exp_q.push_back(8'h4D);
        send_seq(seq, DIR_LSB_FIRST, 0);
        idle(2);
        exp_q.push_back(8'h4D);
        send_seq(seq, DIR_LSB_FIRST, 3);
        idle(2);

        // Overrun: second word dropped, first held
        D_rdy = 1'b0;
        send_frame(8'hA5, DIR_MSB_FIRST, 0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h3C, DIR_MSB_FIRST, 0, 1'b0, 1'b0, 1'b0);
        idle(1);
        chk("ovr_D_par", D_par, 8'hA5);
        chk("ovr_D_vld", D_vld, 1);
        chk("ovr_set", ovr, 1);
        flag_clr = 1'b1;
        idle(1);
        flag_clr = 1'b0;
        chk("ovr_cleared", ovr, 0);
        D_rdy = 1'b1;
        idle(2);

        // Commit in the same cycle the pending word drains
        D_rdy = 1'b0;
        send_frame(8'h11, DIR_MSB_FIRST, 0, 1'b0, 1'b1, 1'b0);
        idle(2);
        send_frame(8'h22, DIR_LSB_FIRST, 0, 1'b0, 1'b1, 1'b1);
        chk("swap_D_vld", D_vld, 1);
        chk("swap_D_par", D_par, 8'h22);
        chk("swap_ovr", ovr, 0);
        idle(2);

        // Restart after 5 bits, then a full F0 frame
        for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)), i == 0, DIR_LSB_FIRST);
        send_frame(8'hF0, DIR_MSB_FIRST, 0, 1'b0, 1'b1, 1'b0);
        idle(2);
        chk("abort_ovr", ovr, 0);
        chk("abort_perr", perr, 0);

        // Reset mid-frame with a pending word
        D_rdy = 1'b0;
        send_frame(8'h5A, DIR_MSB_FIRST, 0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, i == 0, DIR_MSB_FIRST);
        Clr_b = 1'b0;
        #1;
        chk("clr_D_vld", D_vld, 0);
        chk("clr_D_par", D_par, 0);
        chk("clr_busy", busy, 0);
        idle(1);
        Clr_b = 1'b1;
        D_rdy = 1'b1;
        send_frame(8'hC3, DIR_LSB_FIRST, 0, 1'b0, 1'b1, 1'b0);
        idle(2);

`ifdef SER2PAR_PARITY_EN
        send_frame(8'hB2, DIR_MSB_FIRST, 0, 1'b0, 1'b1, 1'b0);
        idle(2);
        send_frame(8'hB2, DIR_MSB_FIRST, 0, 1'b1, 1'b1, 1'b0);
        chk("perr_D_vld", D_vld, 0);
        chk("perr_set", perr, 1);
        flag_clr = 1'b1;
        idle(1);
        flag_clr = 1'b0;
        chk("perr_cleared", perr, 0);
`endif

        // Random frames: random direction, gaps, aborts and parity errors
        for (int n = 0; n < 60; n++) begin
            w   = W'($urandom);
            d   = 1'($urandom_range(0, 1));
            bad = 1'b0;
            if (PAR_EN && $urandom_range(0, 5) == 0) bad = 1'b1;
            if (bad) bad_cnt++;
            if ($urandom_range(0, 6) == 0) begin
                k = $urandom_range(1, W - 1);
                for (int i = 0; i < k; i++) send_bit(1'($urandom_range(0, 1)), i == 0, d);
            end
            send_frame(w, d, $urandom_range(0, 2), bad, 1'b1, 1'b0);
            idle($urandom_range(0, 1));
        end
        idle(5);
        chk("rand_ovr", ovr, 0);
        chk("rand_perr", perr, (bad_cnt > 0) ? 1 : 0);

        for (int t = 0; t < 50 && exp_q.size() != 0; t++) idle(1);
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ser2par_rx.md
# ser2par_rx

Serial-to-parallel receiver: the receiving end of the serial link driven by the team's universal shift register in shift mode. Collects a framed stream of `WIDTH` serial bits, either MSB-first or LSB-first, into a parallel word. Presents the word through a one-entry holding register with a valid/ready handshake. Sits between the serial link pins and the parallel consumer logic.

## Interface
- `WIDTH`, 8, data bits per frame (≥2)
- `CLK`  in  1  clock, all state updates on rising edge
- `Clr_b`  in  1  reset, asynchronous, active-low
- `ser_in`  in  1  serial data bit, sampled only when `ser_vld`=1
- `ser_vld`  in  1  bit strobe; one bit consumed per cycle with `ser_vld`=1
- `ser_sof`  in  1  start of frame; qualifies the bit presented with `ser_vld` as bit 0 of a new frame
- `dir`  in  1  0 = MSB-first (shift left, new bit into bit 0); 1 = LSB-first (shift right, new bit into bit `WIDTH`-1); sampled at SOF, held per frame
- `D_par`  out  `WIDTH`  received word (holding register)
- `D_vld`  out  1  holding register full
- `D_rdy`  in  1  consumer accepts `D_par` when `D_vld`&`D_rdy`
- `busy`  out  1  frame in progress (state ≠ IDLE)
- `ovr`  out  1  sticky overrun flag
- `perr`  out  1  sticky parity-error flag (tied 0 when parity compiled out)
- `flag_clr`  in  1  synchronous clear of `ovr` and `perr`

## Operation
- Reset values: `D_par`=0, `D_vld`=0, `busy`=0, `ovr`=0, `perr`=0. Internally: shift register = 0, bit counter = 0, state = IDLE.
- States: IDLE, SHIFT, PAR (PAR exists only with parity enabled).
- IDLE:
  - `ser_vld`&`ser_sof` → load the first bit, latch `dir`, count=1, go to SHIFT.
  - `ser_vld` without `ser_sof` → bit ignored.
- SHIFT: each `ser_vld` shifts one bit in and increments the count.
  - The bit that brings count to `WIDTH` completes the data field.
  - Without parity, completion means commit and go to IDLE.
  - With parity, completion means go to PAR.
- PAR: the next `ser_vld` bit is the even-parity bit (XOR of data bits ^ parity bit = 0).
  - Pass → commit.
  - Fail → discard the word, set `perr`.
  - Either way, go to IDLE.
- `ser_sof`&`ser_vld` in SHIFT or PAR: the partial frame is silently discarded and a new frame restarts with this bit (count=1, new `dir`).
- Commit: if `D_vld`=0, or `D_vld`&`D_rdy` in the same cycle, the word is written to `D_par` and `D_vld`=1. Otherwise the new word is dropped, `ovr` is set, and `D_par` is unchanged.
- Consume: `D_vld`&`D_rdy` without a simultaneous commit → `D_vld`=0. `D_par` holds its last value.
- `flag_clr` clears `ovr`/`perr`. If a set event occurs in the same cycle, the set wins.
- Bit counter width is clog2(`WIDTH`+1). It never wraps; it is reset to 0 on every commit or abort.

## Timing
- `D_vld` rises the cycle after the clock edge that samples the last data bit (no parity) or the parity bit (with parity). Latency is 1 cycle.
- `ser_vld` may have arbitrary gaps. The state machine waits in place without time-out.
- The back-to-back rate is one frame per `WIDTH` (+1 with parity) strobes. A new SOF is legal in the cycle right after completion.
- `busy` is a registered value. It is 1 from the cycle after SOF until the cycle after completion.
- `Clr_b` asserted mid-frame or with `D_vld`=1 returns everything to reset values immediately. The partial or pending word is lost.

## Configuration
- `SER2PAR_PARITY_EN` defined:
  - PAR state present; the frame is `WIDTH`+1 bits.
  - Even parity is checked.
  - `perr` is live.
- Not defined:
  - The frame is `WIDTH` bits.
  - No PAR state; `perr` is constant 0.
  - The port list is unchanged.

## Structure
- Shared package `ser_link_pkg`:
  - state encoding typedef (IDLE=2'b00, SHIFT=2'b01, PAR=2'b10)
  - `DIR_MSB_FIRST`=0 and `DIR_LSB_FIRST`=1 constants
  - default `WIDTH`
- One sub-module, `rx_hold_reg`: the one-entry holding register with valid/ready and overrun detection. The FSM and shifter live in the top module.

## Test plan
- MSB-first, `WIDTH`=8, bits 1,0,1,1,0,0,1,0 with continuous strobes and `D_rdy`=1 → `D_par`=8'hB2, `D_vld` high 1 cycle after the 8th bit.
- LSB-first, same bit sequence → `D_par`=8'h4D. Repeat with `ser_vld` gaps of 3 cycles between bits → same result.
- `D_rdy`=0, two frames 8'hA5 then 8'h3C → `D_par` stays 8'hA5 and `ovr`=1. Pulse `flag_clr` → `ovr`=0.
- Frame completes in the same cycle as `D_rdy`=1 with a pending 8'h11 → new 8'h22 is accepted, `D_vld` stays 1, `ovr`=0.
- SOF reasserted after 5 bits, then a full frame 8'hF0 → `D_par`=8'hF0, no flags set. Separately, `Clr_b` pulsed after 4 bits → all outputs 0, next frame receives correctly.
- With `SER2PAR_PARITY_EN`: 8'hB2 followed by parity bit 0 → accepted. 8'hB2 followed by parity bit 1 → `D_vld` stays 0, `perr`=1.
